// File: rtl/eth_helper_pkg.sv
// Shared widths and payload word type for the Ethernet frame path.
package eth_helper_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned PKT_SIZE_W = 14;

  typedef logic [63:0] payload_word_t;

endpackage

// File: rtl/payload_fifo_mem.sv
// Simple dual-port payload storage: synchronous write, asynchronous read.
module payload_fifo_mem #(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents survive reset; occupancy tracking decides what is valid.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/payload_staging_fifo.sv
// FWFT payload buffer ahead of the frame former; reports empty until a full frame is resident.
// Optional statistics outputs are enabled with `define PAYLOAD_FIFO_STATS_EN.
module payload_staging_fifo
  import eth_helper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = eth_helper_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 2048,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic [PKT_SIZE_W-1:0] Payload_Words,
  input  logic                  FFMready,
  output logic [DATA_WIDTH-1:0] Output_Data,
  output logic                  is_empty,
  output logic                  is_full,
  output logic [AW:0]           Occupancy
`ifdef PAYLOAD_FIFO_STATS_EN
  ,
  output logic [15:0]           Underflow_Count,
  output logic [7:0]            Frames_Available
`endif
);

  logic [AW:0]           occ_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic                  underflow_sticky_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  not_empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] head_word;

  assign not_empty = (occ_q != '0);
  assign full      = (occ_q == (AW+1)'(DEPTH));

  // Handshake depends only on registered state so tready never loops through tvalid.
  assign S_AXIS_tready = !full && !ARESET;
  assign wr_en         = S_AXIS_tvalid && S_AXIS_tready;
  assign rd_en         = FFMready && not_empty;

  assign is_full   = full;
  assign is_empty  = (32'(occ_q) < 32'(Payload_Words)) || (Payload_Words == '0);
  assign Occupancy = occ_q;

  // Underrunning reads return zeros, never stale memory.
  assign Output_Data = not_empty ? head_word : '0;

  payload_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .ACLK    (ACLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (S_AXIS_tdata),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      occ_q              <= '0;
      underflow_sticky_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: ;
      endcase
      if (FFMready && !not_empty) underflow_sticky_q <= 1'b1;
    end
  end

  cover property (@(posedge ACLK) underflow_sticky_q);

`ifdef PAYLOAD_FIFO_STATS_EN
  logic [31:0] frames_c;

  always_comb begin
    frames_c = '0;
    if (Payload_Words != '0) frames_c = 32'(occ_q) / 32'(Payload_Words);
  end

  // Frame count saturates at the 8-bit output range.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      Underflow_Count  <= '0;
      Frames_Available <= '0;
    end else begin
      if (FFMready && !not_empty && (Underflow_Count != 16'hFFFF))
        Underflow_Count <= Underflow_Count + 16'd1;
      Frames_Available <= (frames_c > 32'd255) ? 8'hFF : frames_c[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_payload_staging_fifo.sv
// Scoreboard bench for payload_staging_fifo built with a 16-entry FIFO.
module tb_payload_staging_fifo;
  import eth_helper_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  payload_word_t S_AXIS_tdata = '0;
  logic          S_AXIS_tvalid = 1'b0;
  logic          S_AXIS_tready;
  logic [13:0]   Payload_Words = 14'd4;
  logic          FFMready = 1'b0;
  payload_word_t Output_Data;
  logic          is_empty;
  logic          is_full;
  logic [AW:0]   Occupancy;
`ifdef PAYLOAD_FIFO_STATS_EN
  logic [15:0]   Underflow_Count;
  logic [7:0]    Frames_Available;
  int            exp_uf;
  int            exp_fa;
`endif

  payload_word_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  payload_staging_fifo #(.DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .Payload_Words (Payload_Words),
    .FFMready      (FFMready),
    .Output_Data   (Output_Data),
    .is_empty      (is_empty),
    .is_full       (is_full),
    .Occupancy     (Occupancy)
`ifdef PAYLOAD_FIFO_STATS_EN
    ,
    .Underflow_Count  (Underflow_Count),
    .Frames_Available (Frames_Available)
`endif
  );

  always #5 ACLK = ~ACLK;

  function automatic payload_word_t exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 64'd0;
  endfunction

  // One clock with the given inputs; the model updates from its own pre-edge state.
  task automatic tick(input logic v, input payload_word_t d, input logic f);
    bit do_push;
    bit do_pop;
    int sz;
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = d;
    FFMready      = f;
    @(posedge ACLK);
    sz      = exp_q.size();
    do_pop  = f && (sz != 0);
    do_push = v && (sz != int'(DEPTH));
`ifdef PAYLOAD_FIFO_STATS_EN
    if (f && sz == 0 && exp_uf < 65535) exp_uf++;
    exp_fa = (Payload_Words == 0) ? 0 : sz / int'(Payload_Words);
    if (exp_fa > 255) exp_fa = 255;
`endif
    if (do_pop) exp_q.delete(0);
    if (do_push) exp_q.push_back(d);
    #1;
    S_AXIS_tvalid = 1'b0;
    FFMready      = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    S_AXIS_tvalid = 1'b0;
    FFMready = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXIS_tready !== 1'b0) begin
      failures++;
      $display("FAIL rst_tready_low got=%b exp=0", S_AXIS_tready);
    end
    @(posedge ACLK);
    exp_q.delete();
`ifdef PAYLOAD_FIFO_STATS_EN
    exp_uf = 0;
    exp_fa = 0;
`endif
    #1;
    ARESET = 1'b0;
    #1;
    checks++;
    if (S_AXIS_tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_tready_high got=%b exp=1", S_AXIS_tready);
    end
    checks++;
    if (Occupancy !== '0) begin
      failures++;
      $display("FAIL rst_occ got=%0d exp=0", Occupancy);
    end
    checks++;
    if (is_empty !== 1'b1 || is_full !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b exp=10", is_empty, is_full);
    end
    checks++;
    if (Output_Data !== 64'd0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", Output_Data);
    end
`ifdef PAYLOAD_FIFO_STATS_EN
    checks++;
    if (Underflow_Count !== 16'd0 || Frames_Available !== 8'd0) begin
      failures++;
      $display("FAIL rst_stats got=%0d/%0d exp=0/0", Underflow_Count, Frames_Available);
    end
`endif
  endtask

  task automatic test_gating();
    payload_word_t w [4] = '{64'h11, 64'h22, 64'h33, 64'h44};
    Payload_Words = 14'd4;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, w[i], 1'b0);
      checks++;
      if (is_empty !== 1'b1) begin
        failures++;
        $display("FAIL gate_empty_%0d got=%b exp=1", i, is_empty);
      end
    end
    tick(1'b1, w[3], 1'b0);
    checks++;
    if (is_empty !== 1'b0) begin
      failures++;
      $display("FAIL gate_ready got=%b exp=0", is_empty);
    end
    checks++;
    if (Output_Data !== exp_head() || Output_Data !== 64'h11) begin
      failures++;
      $display("FAIL gate_head got=%h exp=%h", Output_Data, exp_head());
    end
  endtask

  task automatic test_frame_drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Output_Data !== exp_head()) begin
        failures++;
        $display("FAIL drain_word_%0d got=%h exp=%h", i, Output_Data, exp_head());
      end
      tick(1'b0, 64'd0, 1'b1);
`ifdef PAYLOAD_FIFO_STATS_EN
      if (i == 0) begin
        checks++;
        if (int'(Frames_Available) != exp_fa) begin
          failures++;
          $display("FAIL drain_frames got=%0d exp=%0d", Frames_Available, exp_fa);
        end
      end
`endif
    end
    checks++;
    if (Output_Data !== 64'd0 || Occupancy !== '0 || is_empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_end got=%h/%0d/%b exp=0/0/1", Output_Data, Occupancy, is_empty);
    end
  endtask

  task automatic drain_all(input string tag);
    for (int n = 0; n < 2 * int'(DEPTH) && exp_q.size() != 0; n++) begin
      checks++;
      if (Output_Data !== exp_head()) begin
        failures++;
        $display("FAIL %s_order_%0d got=%h exp=%h", tag, n, Output_Data, exp_head());
      end
      tick(1'b0, 64'd0, 1'b1);
    end
    checks++;
    if (Occupancy !== '0) begin
      failures++;
      $display("FAIL %s_drained got=%0d exp=0", tag, Occupancy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) tick(1'b1, 64'h100 + 64'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (Output_Data !== exp_head()) begin
        failures++;
        $display("FAIL b2b_head_%0d got=%h exp=%h", i, Output_Data, exp_head());
      end
      tick(1'b1, 64'h200 + 64'(i), 1'b1);
      checks++;
      if (int'(Occupancy) != exp_q.size() || Occupancy !== 5'd10) begin
        failures++;
        $display("FAIL b2b_occ_%0d got=%0d exp=%0d", i, Occupancy, exp_q.size());
      end
    end
    drain_all("b2b");
  endtask

  task automatic test_full_wrap();
    test_reset();
    for (int i = 0; i < 16; i++) tick(1'b1, 64'h300 + 64'(i), 1'b0);
    checks++;
    if (is_full !== 1'b1 || S_AXIS_tready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags got=%b/%b exp=1/0", is_full, S_AXIS_tready);
    end
    tick(1'b1, 64'hDEAD, 1'b0);
    checks++;
    if (int'(Occupancy) != exp_q.size()) begin
      failures++;
      $display("FAIL full_blocked got=%0d exp=%0d", Occupancy, exp_q.size());
    end
    tick(1'b0, 64'd0, 1'b1);
    checks++;
    if (S_AXIS_tready !== 1'b1 || is_full !== 1'b0 || Occupancy !== 5'd15) begin
      failures++;
      $display("FAIL full_pop got=%b/%b/%0d exp=1/0/15", S_AXIS_tready, is_full, Occupancy);
    end
    tick(1'b1, 64'h310, 1'b0);
    checks++;
    if (Occupancy !== 5'd16) begin
      failures++;
      $display("FAIL full_17th got=%0d exp=16", Occupancy);
    end
    drain_all("wrap");
  endtask

  task automatic test_underflow();
    test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 64'd0, 1'b1);
      checks++;
      if (Output_Data !== 64'd0 || Occupancy !== '0) begin
        failures++;
        $display("FAIL uf_idle_%0d got=%h/%0d exp=0/0", i, Output_Data, Occupancy);
      end
    end
`ifdef PAYLOAD_FIFO_STATS_EN
    checks++;
    if (int'(Underflow_Count) != exp_uf) begin
      failures++;
      $display("FAIL uf_count got=%0d exp=%0d", Underflow_Count, exp_uf);
    end
`endif
    tick(1'b1, 64'h55, 1'b0);
    checks++;
    if (Output_Data !== exp_head() || Occupancy !== 5'd1) begin
      failures++;
      $display("FAIL uf_after got=%h/%0d exp=%h/1", Output_Data, Occupancy, exp_head());
    end
    drain_all("uf");
  endtask

  task automatic test_reset_mid_frame();
    Payload_Words = 14'd8;
    for (int i = 0; i < 8; i++) tick(1'b1, 64'h400 + 64'(i), 1'b0);
    tick(1'b0, 64'd0, 1'b1);
    tick(1'b0, 64'd0, 1'b1);
    checks++;
    if (Output_Data !== exp_head() || Occupancy !== 5'd6) begin
      failures++;
      $display("FAIL mid_pre got=%h/%0d exp=%h/6", Output_Data, Occupancy, exp_head());
    end
    test_reset();
    tick(1'b1, 64'h66, 1'b0);
    checks++;
    if (Output_Data !== 64'h66 || Occupancy !== 5'd1 || is_empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_head got=%h/%0d/%b exp=66/1/1", Output_Data, Occupancy, is_empty);
    end
  endtask

  initial begin
    test_reset();
    test_gating();
    test_frame_drain();
    test_back_to_back();
    test_full_wrap();
    test_underflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
